// File: rtl/matmul_traffic_gen.sv
// matmul_traffic_gen
// Bus master that computes C[MxN] = A[MxK] * B[KxN] through the C1/A1/D1 cache bus.
// Element sizes: A is 8-bit, B is 16-bit and C is 32-bit. All three matrices are
// row-major and packed back to back from byte address 0.
// Every access is a two-cycle issue: the line address goes out first, then the offset.
// The master then waits for the responder to drive c1_in == 7.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i, cfg_m/n/k_i    start pulse and matrix dimensions (latched when the start is accepted)
//   busy_o, done_o, error_o run status; error_o is only live with MMGEN_TIMEOUT_EN
//   c1_out_o/c1_oe_o/c1_in_i  command bus (drive value, drive enable, sampled value)
//   a1_out_o                address bus (line address, then offset)
//   d1_out_o/d1_oe_o/d1_in_i  data bus
//   req_count_o, hit_count_o, cycle_count_o  run statistics
// Optional feature: define MMGEN_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles.
module matmul_traffic_gen #(
  parameter int ADDR_W      = 18,
  parameter int OFFSET_W    = 4,
  parameter int A1_W        = 14,
  parameter int D1_W        = 16,
  parameter int C1_W        = 3,
  parameter int DIM_W       = 8,
  parameter int HIT_LATENCY = 6,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [DIM_W-1:0] cfg_m_i,
  input  logic [DIM_W-1:0] cfg_n_i,
  input  logic [DIM_W-1:0] cfg_k_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [C1_W-1:0]  c1_out_o,
  output logic             c1_oe_o,
  input  logic [C1_W-1:0]  c1_in_i,
  output logic [A1_W-1:0]  a1_out_o,
  output logic [D1_W-1:0]  d1_out_o,
  output logic             d1_oe_o,
  input  logic [D1_W-1:0]  d1_in_i,
  output logic [CNT_W-1:0] req_count_o,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  localparam logic [C1_W-1:0] CMD_NOP     = C1_W'(0);
  localparam logic [C1_W-1:0] CMD_READ8   = C1_W'(1);
  localparam logic [C1_W-1:0] CMD_READ16  = C1_W'(2);
  localparam logic [C1_W-1:0] CMD_WRITE32 = C1_W'(7);
  localparam logic [C1_W-1:0] RSP_READY   = C1_W'(7);
  // The latency counter saturates, so it must cover both the hit window and the watchdog limit.
  localparam int LAT_W = $clog2(TIMEOUT + HIT_LATENCY + 2) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_HI, S_ISSUE_LO, S_WAIT, S_MAC, S_NEXT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [C1_W-1:0]    cmd_q, cmd_d;
  logic [DIM_W-1:0]   m_q, m_d, n_q, n_d, kd_q, kd_d;
  logic [DIM_W-1:0]   y_q, y_d, x_q, x_d, k_q, k_d;
  logic [31:0]        s_q, s_d;
  logic [7:0]         a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   req_q, req_d, hit_q, hit_d, cyc_q, cyc_d;

  // Addresses are computed at ADDR_W bits and wrap modulo 2**ADDR_W.
  logic [ADDR_W-1:0] m_a, n_a, kd_a, y_a, x_a, k_a;
  logic [ADDR_W-1:0] base_b, base_c, addr;

  always_comb begin
    m_a    = ADDR_W'(m_q);
    n_a    = ADDR_W'(n_q);
    kd_a   = ADDR_W'(kd_q);
    y_a    = ADDR_W'(y_q);
    x_a    = ADDR_W'(x_q);
    k_a    = ADDR_W'(k_q);
    base_b = m_a * kd_a;
    base_c = base_b + ((kd_a * n_a) << 1);
    unique case (cmd_q)
      CMD_READ8:  addr = y_a * kd_a + k_a;
      CMD_READ16: addr = base_b + ((k_a * n_a + x_a) << 1);
      default:    addr = base_c + ((y_a * n_a + x_a) << 2);
    endcase
  end

  always_comb begin
    c1_oe_o  = 1'b0;
    c1_out_o = CMD_NOP;
    a1_out_o = '0;
    d1_oe_o  = 1'b0;
    d1_out_o = '0;
    unique case (state_q)
      S_ISSUE_HI: begin
        c1_oe_o  = 1'b1;
        c1_out_o = cmd_q;
        a1_out_o = A1_W'(addr >> OFFSET_W);
        if (cmd_q == CMD_WRITE32) begin
          d1_oe_o  = 1'b1;
          d1_out_o = D1_W'(s_q[15:0]);
        end
      end
      S_ISSUE_LO: begin
        c1_oe_o  = 1'b1;
        c1_out_o = cmd_q;
        a1_out_o = A1_W'(addr[OFFSET_W-1:0]);
        if (cmd_q == CMD_WRITE32) begin
          d1_oe_o  = 1'b1;
          d1_out_o = D1_W'(s_q[31:16]);
        end
      end
      default: ;
    endcase
  end

`ifdef MMGEN_TIMEOUT_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    m_d     = m_q;
    n_d     = n_q;
    kd_d    = kd_q;
    y_d     = y_q;
    x_d     = x_q;
    k_d     = k_q;
    s_d     = s_q;
    a_d     = a_q;
    b_d     = b_q;
    lat_d   = lat_q;
    req_d   = req_q;
    hit_d   = hit_q;
    cyc_d   = cyc_q;
`ifdef MMGEN_TIMEOUT_EN
    err_d   = err_q;
`endif
    if (state_q != S_IDLE) cyc_d = cyc_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          m_d   = cfg_m_i;
          n_d   = cfg_n_i;
          kd_d  = cfg_k_i;
          y_d   = '0;
          x_d   = '0;
          k_d   = '0;
          s_d   = '0;
          cmd_d = CMD_READ8;
          req_d = '0;
          hit_d = '0;
          cyc_d = CNT_W'(1);  // the accepting cycle is part of the run
`ifdef MMGEN_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (cfg_m_i == '0 || cfg_n_i == '0 || cfg_k_i == '0) state_d = S_DONE;
          else                                                  state_d = S_ISSUE_HI;
        end
      end
      S_ISSUE_HI: begin
        req_d   = req_q + 1'b1;
        state_d = S_ISSUE_LO;
      end
      S_ISSUE_LO: begin
        lat_d   = LAT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (c1_in_i == RSP_READY) begin
          if (lat_q <= LAT_W'(HIT_LATENCY)) hit_d = hit_q + 1'b1;
          unique case (cmd_q)
            CMD_READ8: begin
              a_d     = d1_in_i[7:0];
              cmd_d   = CMD_READ16;
              state_d = S_ISSUE_HI;
            end
            CMD_READ16: begin
              b_d     = d1_in_i[15:0];
              state_d = S_MAC;
            end
            default: state_d = S_NEXT;
          endcase
        end else begin
          if (lat_q != '1) lat_d = lat_q + 1'b1;
`ifdef MMGEN_TIMEOUT_EN
          if (lat_q >= LAT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_MAC: begin
        s_d     = s_q + 32'(a_q) * 32'(b_q);
        state_d = S_ISSUE_HI;
        if (k_q == kd_q - 1'b1) begin
          k_d   = '0;
          cmd_d = CMD_WRITE32;
        end else begin
          k_d   = k_q + 1'b1;
          cmd_d = CMD_READ8;
        end
      end
      S_NEXT: begin
        s_d     = '0;
        cmd_d   = CMD_READ8;
        state_d = S_ISSUE_HI;
        if (x_q == n_q - 1'b1) begin
          x_d = '0;
          if (y_q == m_q - 1'b1) state_d = S_DONE;
          else                   y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_NOP;
      m_q     <= '0;
      n_q     <= '0;
      kd_q    <= '0;
      y_q     <= '0;
      x_q     <= '0;
      k_q     <= '0;
      s_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lat_q   <= '0;
      req_q   <= '0;
      hit_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      m_q     <= m_d;
      n_q     <= n_d;
      kd_q    <= kd_d;
      y_q     <= y_d;
      x_q     <= x_d;
      k_q     <= k_d;
      s_q     <= s_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lat_q   <= lat_d;
      req_q   <= req_d;
      hit_q   <= hit_d;
      cyc_q   <= cyc_d;
    end
  end

`ifdef MMGEN_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign req_count_o   = req_q;
  assign hit_count_o   = hit_q;
  assign cycle_count_o = cyc_q;

endmodule
